// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// neuron_pkg: Q4.4 types, shared widths, MAC state enum, round/saturate helper
// Revision: 1.0
// ============================================================================
package neuron_pkg;

   localparam int DATA_W = 8;
   localparam int FRAC_W = 4;
   localparam int ACC_W  = 20;
   localparam int RND_W  = ACC_W + 1;

   typedef logic signed [DATA_W-1:0] data_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Round half up, arithmetic shift back to Q4.4, then clamp to the data range.
   function automatic data_t q_round_sat(acc_t a);
      logic signed [RND_W-1:0] biased;
      logic signed [RND_W-1:0] shifted;
      logic signed [RND_W-1:0] sat_max;
      logic signed [RND_W-1:0] sat_min;
      sat_max = RND_W'(2**(DATA_W-1) - 1);
      sat_min = RND_W'(-(2**(DATA_W-1)));
      biased  = RND_W'(a) + RND_W'(2**(FRAC_W-1));
      shifted = biased >>> FRAC_W;
      if (shifted > sat_max) begin
         q_round_sat = sat_max[DATA_W-1:0];
      end else if (shifted < sat_min) begin
         q_round_sat = sat_min[DATA_W-1:0];
      end else begin
         q_round_sat = shifted[DATA_W-1:0];
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_mac_if.sv
`default_nettype none
// ============================================================================
// neuron_mac_if: beat-in / result-out valid-ready bundle of the neuron MAC
// Revision: 1.0
// ============================================================================
interface neuron_mac_if #(
   parameter int DATA_W = neuron_pkg::DATA_W
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_x;
   logic signed [DATA_W-1:0] in_w;
   logic signed [DATA_W-1:0] in_bias;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] z_value;

   modport master (
      output in_valid, in_x, in_w, in_bias, out_ready,
      input  in_ready, out_valid, z_value
   );

   modport slave (
      input  in_valid, in_x, in_w, in_bias, out_ready,
      output in_ready, out_valid, z_value
   );
endinterface
`default_nettype wire

// File: rtl/neuron_mac_round_sat.sv
`default_nettype none
// ============================================================================
// neuron_mac_round_sat: round-half-up and saturate an accumulator to DATA_W
// Revision: 1.0
// ============================================================================
module neuron_mac_round_sat #(
   parameter int DATA_W = neuron_pkg::DATA_W,
   parameter int FRAC_W = neuron_pkg::FRAC_W,
   parameter int ACC_W  = neuron_pkg::ACC_W
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] z
);
   // One extra bit so the rounding increment can never wrap the top of the range.
   localparam int RND_W = ACC_W + 1;
   localparam logic signed [RND_W-1:0] HALF    = RND_W'(2**(FRAC_W-1));
   localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(2**(DATA_W-1) - 1);
   localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-(2**(DATA_W-1)));

   logic signed [RND_W-1:0] biased;
   logic signed [RND_W-1:0] shifted;

   always_comb begin
      biased  = RND_W'(acc) + HALF;
      shifted = biased >>> FRAC_W;
      if (shifted > SAT_MAX) begin
         z = SAT_MAX[DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
         z = SAT_MIN[DATA_W-1:0];
      end else begin
         z = shifted[DATA_W-1:0];
      end
   end
endmodule
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// neuron_mac: serial Q4.4 multiply-accumulate with bias, rounded result held
//             on a valid/ready output until consumed
// Revision: 1.0
// ============================================================================
module neuron_mac #(
   parameter int N_INPUTS = 2,
   parameter int DATA_W   = neuron_pkg::DATA_W,
   parameter int FRAC_W   = neuron_pkg::FRAC_W,
   parameter int ACC_W    = neuron_pkg::ACC_W
) (
   input  logic        clk,
   input  logic        rst,
   neuron_mac_if.slave bus
);
   import neuron_pkg::*;

   localparam int PROD_W = 2 * DATA_W;
   localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

   if (ACC_W < 2 * DATA_W + $clog2(N_INPUTS + 1)) begin : g_acc_w_check
      $error("neuron_mac: ACC_W too narrow for N_INPUTS products");
   end

   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] z_reg;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_step;
   logic signed [ACC_W-1:0]  sum;
   logic signed [DATA_W-1:0] z_next;

   always_comb begin
      prod     = PROD_W'(bus.in_x) * PROD_W'(bus.in_w);
      acc_step = acc + ACC_W'(prod);
      // Bias is Q4.4; align it to the Q8.8 products before adding.
      sum      = acc_step + (ACC_W'(bus.in_bias) <<< FRAC_W);
   end

   neuron_mac_round_sat #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_round_sat (
      .acc (sum),
      .z   (z_next)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ACCUM;
         cnt   <= '0;
         acc   <= '0;
         z_reg <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (bus.in_valid) begin
                  if (cnt == LAST) begin
                     z_reg <= z_next;
                     acc   <= '0;
                     cnt   <= '0;
                     state <= HOLD;
                  end else begin
                     acc <= acc_step;
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == HOLD);
   assign bus.z_value   = z_reg;
endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// tb_neuron_mac: directed and randomized checks of neuron_mac against an
//                integer weighted-sum model
// Revision: 1.0
// ============================================================================
module tb_neuron_mac;
   localparam int N  = 2;
   localparam int DW = 8;
   localparam int FW = 4;
   localparam int AW = 20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   neuron_mac_if #(.DATA_W(DW)) bus ();

   neuron_mac #(
      .N_INPUTS (N),
      .DATA_W   (DW),
      .FRAC_W   (FW),
      .ACC_W    (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Real-valued weighted sum in units of 1/256, rounded half up to 1/16, clamped.
   function automatic int model(input int x[N], input int w[N], input int b);
      int s;
      s = b * 256 / 16 * 16;
      s = b * 16;
      for (int i = 0; i < N; i++) s += x[i] * w[i];
      s = $floor((real'(s) + 8.0) / 16.0);
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   function automatic int rnd8();
      return int'($urandom_range(255, 0)) - 128;
   endfunction

   task automatic run_vec(input int x[N], input int w[N], input int b,
                          input int exp, input int gap, input string tag);
      for (int i = 0; i < N; i++) begin
         bus.in_valid = 1'b1;
         bus.in_x     = DW'(x[i]);
         bus.in_w     = DW'(w[i]);
         bus.in_bias  = (i == N - 1) ? DW'(b) : DW'($urandom);
         checks++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_beat%0d: in_ready=%b out_valid=%b, want 1 0",
                     tag, i, bus.in_ready, bus.out_valid);
         end
         @(posedge clk); #1;
         if (i < N - 1 && gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) begin
               bus.in_x = DW'($urandom);
               bus.in_w = DW'($urandom);
               @(posedge clk); #1;
            end
         end
      end
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.z_value !== DW'(exp)) begin
         errors++;
         $display("FAIL %s_result: out_valid=%b z=%0d, want 1 %0d",
                  tag, bus.out_valid, bus.z_value, exp);
      end
   endtask

   task automatic consume(input int exp, input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.z_value !== DW'(exp)) begin
         errors++;
         $display("FAIL %s_consume: out_valid=%b in_ready=%b z=%0d, want 0 1 %0d",
                  tag, bus.out_valid, bus.in_ready, bus.z_value, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.in_valid = 1'b1;
      repeat (3) begin
         bus.in_x = DW'($urandom);
         bus.in_w = DW'($urandom);
         @(posedge clk); #1;
         checks++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.z_value !== 8'sd0) begin
            errors++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b z=%0d, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.z_value);
         end
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.z_value !== 8'sd0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b z=%0d, want 1 0 0",
                  bus.in_ready, bus.out_valid, bus.z_value);
      end
   endtask

   task automatic test_directed();
      int x[N];
      int w[N];
      x = '{16, 16};   w = '{16, 16};  run_vec(x, w, 0, 32, 0, "unity");     consume(32, "unity");
      x = '{1, 0};     w = '{8, 0};    run_vec(x, w, 0, 1, 0, "rnd_half");   consume(1, "rnd_half");
      x = '{1, 0};     w = '{7, 0};    run_vec(x, w, 0, 0, 0, "rnd_below");  consume(0, "rnd_below");
      x = '{-1, 0};    w = '{8, 0};    run_vec(x, w, 0, 0, 0, "rnd_neghalf"); consume(0, "rnd_neghalf");
      x = '{-1, 0};    w = '{9, 0};    run_vec(x, w, 0, -1, 0, "rnd_neg");   consume(-1, "rnd_neg");
      x = '{127, 127}; w = '{127, 127}; run_vec(x, w, 0, 127, 0, "sat_pos"); consume(127, "sat_pos");
      x = '{-128, -128}; w = '{127, 127}; run_vec(x, w, 0, -128, 0, "sat_neg"); consume(-128, "sat_neg");
      x = '{16, 0};    w = '{16, 0};   run_vec(x, w, 127, 127, 0, "sat_bias"); consume(127, "sat_bias");
   endtask

   task automatic test_back_pressure();
      int x[N];
      int w[N];
      x = '{16, 16}; w = '{16, 16};
      run_vec(x, w, 0, 32, 0, "bp_a");
      bus.in_valid = 1'b1;
      bus.in_x     = 8'sd16;
      bus.in_w     = 8'sd16;
      bus.in_bias  = DW'($urandom);
      repeat (5) begin
         @(posedge clk); #1;
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.z_value !== 8'sd32) begin
            errors++;
            $display("FAIL bp_hold: in_ready=%b out_valid=%b z=%0d, want 0 1 32",
                     bus.in_ready, bus.out_valid, bus.z_value);
         end
      end
      // Consume while the next beat is already offered; it must not be taken yet.
      consume(32, "bp_a");
      x = '{16, 32}; w = '{16, 16};
      run_vec(x, w, 0, 48, 0, "bp_b");
      consume(48, "bp_b");
   endtask

   task automatic test_gaps();
      int x[N];
      int w[N];
      x = '{16, 16}; w = '{16, 16};
      run_vec(x, w, 0, 32, 3, "gap");
      consume(32, "gap");
   endtask

   task automatic test_reset_mid();
      int x[N];
      int w[N];
      bus.in_valid = 1'b1;
      bus.in_x     = 8'sd16;
      bus.in_w     = 8'sd16;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.z_value !== 8'sd0) begin
            errors++;
            $display("FAIL rst_mid: in_ready=%b out_valid=%b z=%0d, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.z_value);
         end
      end
      rst = 1'b1;
      x = '{16, 0}; w = '{16, 0};
      run_vec(x, w, 0, 16, 0, "rst_fresh");
      // Reset while holding a result drops it.
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.z_value !== 8'sd0) begin
         errors++;
         $display("FAIL rst_hold: out_valid=%b in_ready=%b z=%0d, want 0 1 0",
                  bus.out_valid, bus.in_ready, bus.z_value);
      end
   endtask

   task automatic test_random();
      int x[N];
      int w[N];
      int b;
      int exp;
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < N; i++) begin
            x[i] = rnd8();
            w[i] = rnd8();
         end
         b   = rnd8();
         exp = model(x, w, b);
         run_vec(x, w, b, exp, int'($urandom_range(2, 0)), "rand");
         repeat ($urandom_range(3, 0)) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.z_value !== DW'(exp)) begin
               errors++;
               $display("FAIL rand_stable: out_valid=%b z=%0d, want 1 %0d",
                        bus.out_valid, bus.z_value, exp);
            end
         end
         consume(exp, "rand");
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_w      = '0;
      bus.in_bias   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_directed();
      test_back_pressure();
      test_gaps();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/neuron_mac.md
# neuron_mac

Weighted-sum stage of one neuron. It consumes a serial stream of (input, weight) pairs in 8-bit Q4.4 fixed point, accumulates the products at full precision and adds a bias. It then rounds and saturates the sum back to Q4.4 and presents the result as `z_value` over a valid/ready handshake. It sits directly upstream of the neuron's LUT-plus-interpolation activation function: `z_value[7:4]` is that block's LUT address and `z_value[3:0]` its interpolation remainder.

## Interface
- `N_INPUTS`, 2: number of (x, w) beats per neuron evaluation; must be ≥ 1.
- `DATA_W`, 8: width of x, w, bias and z_value (signed).
- `FRAC_W`, 4: fractional bits of every DATA_W operand.
- `ACC_W`, 20: accumulator width; must satisfy ACC_W ≥ 2·DATA_W + clog2(N_INPUTS+1).
- `clk` in 1: the only clock; everything is clocked on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: the current beat on in_x / in_w is valid.
- `in_ready` out 1: the block accepts a beat this cycle.
- `in_x` in DATA_W: signed input activation (Q4.4).
- `in_w` in DATA_W: signed weight (Q4.4).
- `in_bias` in DATA_W: signed bias (Q4.4); sampled only on the final beat.
- `out_valid` out 1: `z_value` holds a result.
- `out_ready` in 1: downstream takes the result.
- `z_value` out DATA_W: signed weighted sum (Q4.4), registered.

## Operation
- **Two states.**
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- **Beat acceptance.** A beat is accepted when `in_valid` && `in_ready`. Per accepted beat:
  - `acc += sext(in_x·in_w)`, where the product is a full 2·DATA_W signed value in Q8.8.
  - `cnt` increments.
- **Final beat** (`cnt == N_INPUTS-1`):
  - `sum = acc + prod + (sext(in_bias) << FRAC_W)`.
  - `r = (sum + 2^(FRAC_W-1)) >>> FRAC_W`: round half up, arithmetic shift.
  - `z_value` is r saturated to [-128, 127].
  - `acc` and `cnt` clear to 0.
  - State goes to HOLD.
- **Leaving HOLD.** When `out_ready` is 1, the state returns to ACCUM. `z_value` keeps its last value until the next result.
- **Back-pressure.** Input beats are not accepted in HOLD. Upstream must hold its beat.
- **Reset** (`rst`=0 at a clock edge, including mid-vector or in HOLD):
  - state ← ACCUM.
  - `acc`, `cnt` ← 0.
  - `z_value` ← 0, `out_valid` ← 0.
  - Any partial sum is discarded.
- **Output values after reset.** `in_ready`=1 and `out_valid`=0 in the first cycle after reset deasserts.
- **No overflow before rounding.** The accumulator never wraps, given the ACC_W constraint. Saturation is applied only once, at the final rounding.
- **`in_valid` gaps.** Gaps are allowed between beats; `acc` and `cnt` hold through them.

## Timing
- **Beat rate.** One beat per cycle in ACCUM.
- **Latency.** 1 cycle: a final beat accepted at edge k gives `out_valid`=1 with the new `z_value` from edge k onward (the registered output is visible in cycle k+1).
- **Minimum throughput.** N_INPUTS + 1 cycles per result, with `out_ready` tied high.
- **Simultaneous events in HOLD.**
  - `out_ready`=1 together with `in_valid`=1 in HOLD: the result is consumed and the beat is not accepted.
  - The beat is taken in the next cycle, in ACCUM.
- **Output stability.** `z_value` and `out_valid` are stable while `out_valid`=1 && `out_ready`=0.

## Structure
- **Shared package `neuron_pkg`:**
  - the Q4.4 fixed-point type;
  - the DATA_W/FRAC_W constants, shared with the activation stage;
  - the state enum {ACCUM, HOLD};
  - a saturating round function `q_round_sat(acc_t) -> data_t`.
- **Sub-module `neuron_mac_round_sat`:** combinational rounding and saturation of ACC_W → DATA_W. It is reused by other layers' MAC stages.
- **Remainder of the block:** the top holds the FSM, counter, accumulator and output register.

## Test plan
- **Unity weights.** N=2; beats (16,16), (16,16), bias 0 → `z_value`=32 (2.0), `out_valid` one cycle after the last beat.
- **Rounding.**
  - Beats (1,8), (0,0), bias 0 → 1 (half rounds up).
  - Beats (1,7), (0,0) → 0.
  - Beats (-1,8), (0,0) → 0.
  - Beats (-1,9), (0,0) → -1.
- **Saturation.**
  - Beats (127,127) ×2 → 127.
  - Beats (-128,127) ×2 → -128.
  - Beats (16,16), (0,0), bias 127 → 127.
- **Back-pressure.**
  - `out_ready`=0 for 5 cycles: `in_ready`=0, `z_value` stable, `in_valid` ignored.
  - Then `out_ready`=1: the next vector is accepted from the following cycle.
- **Gaps.** Deassert `in_valid` for 3 cycles between beats → same result as the gap-free run.
- **Reset mid-vector.**
  - Pull `rst` low after beat 1 of (16,16), (16,16).
  - Then send a fresh vector (16,16), (0,0), bias 0 → 16 (no residue from the discarded beat).
  - All outputs read 0 / `in_ready`=1 during reset.
